// File: rtl/hue_fade_pkg.sv
// Shared types for the hue fade engine: mode and phase encodings plus the
// ramp direction. The optional gamma stage is selected in the top by
// HUE_FADE_GAMMA_EN.
package hue_fade_pkg;

  typedef enum logic [1:0] {
    WHEEL   = 2'd0,
    BREATHE = 2'd1,
    HOLD    = 2'd2,
    OFF     = 2'd3
  } mode_t;

  typedef enum logic [2:0] {P0, P1, P2, P3, P4, P5} phase_t;

  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_t;

  // Channel order inside packed duty vectors is {B,G,R}.
  localparam int NUM_CH = 3;

  // Hue phase successor, wrapping P5 back to P0.
  function automatic phase_t phase_inc(input phase_t p);
    return (p == P5) ? P0 : phase_t'(p + 3'd1);
  endfunction

endpackage

// File: rtl/hue_fade_pwm_channel.sv
// One PWM lane: lit is a registered compare of the shared period counter
// against this lane's duty, so the output trails the count by one clock.
module pwm_channel
  import hue_fade_pkg::*;
#(
  parameter  int PWM_INTERVAL = 1200,
  localparam int RW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] count,
  input  logic [RW-1:0] duty,
  output logic          lit
);

  // Lit while the count is below duty: duty 0 never lights, duty M always does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lit <= 1'b0;
    else     lit <= (count < duty);
  end

endmodule

// File: rtl/hue_fade_engine.sv
// RGB hue-wheel / breathe fader. A shared PWM counter drives three
// pwm_channel lanes; the ramp/phase FSM steps once per PWM period and the
// per-channel duties are latched on the period tick so they never change
// mid-period (OFF forces them to zero at once).
// Define HUE_FADE_GAMMA_EN to square-law the duties: floor(d*d/PWM_INTERVAL).
module hue_fade_engine
  import hue_fade_pkg::*;
#(
  parameter int PWM_INTERVAL = 1200,
  parameter int DUTY_STEP    = 10,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic [2:0] rgb_out,
  output logic [2:0] phase,
  output logic       period_tick
);

  localparam int            RW   = $clog2(PWM_INTERVAL + 1);
  localparam logic [RW-1:0] MAXR = RW'(PWM_INTERVAL);
  localparam logic [RW-1:0] STEP = RW'(DUTY_STEP);
  localparam logic [RW-1:0] ZERO = '0;

  mode_t  md, mode_q;
  phase_t phase_q, phase_nxt;
  dir_t   dir_q, dir_nxt, dir_eff;
  logic   entering_br;

  logic [RW-1:0] cnt, ramp_q, ramp_nxt, ramp_up, ramp_dn, inv;
  logic [NUM_CH-1:0][RW-1:0] tgt, applied, duty_q, duty_eff;
  logic [NUM_CH-1:0]         lit;

  assign md          = mode_t'(mode);
  assign period_tick = (cnt == MAXR - 1'b1);
  assign phase       = phase_q;

  // Free-running period counter, 0..PWM_INTERVAL-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (period_tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  // Previous mode, used to spot entry into BREATHE (direction restarts upward).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mode_q <= WHEEL;
    else     mode_q <= md;
  end

  assign entering_br = (md == BREATHE) && (mode_q != BREATHE);
  assign dir_eff     = entering_br ? DIR_UP : dir_q;
  assign ramp_up     = (ramp_q >= MAXR - STEP) ? MAXR : ramp_q + STEP;
  assign ramp_dn     = (ramp_q > STEP) ? ramp_q - STEP : ZERO;

  // Next ramp/phase/direction; a tick that finds the ramp at a bound only
  // wraps (WHEEL) or reverses (BREATHE), it does not also step.
  always_comb begin
    ramp_nxt  = ramp_q;
    phase_nxt = phase_q;
    dir_nxt   = dir_eff;
    case (md)
      WHEEL: begin
        if (ramp_q == MAXR) begin
          ramp_nxt  = ZERO;
          phase_nxt = phase_inc(phase_q);
        end else begin
          ramp_nxt = ramp_up;
        end
      end
      BREATHE: begin
        if (dir_eff == DIR_UP) begin
          if (ramp_q == MAXR) dir_nxt  = DIR_DN;
          else                ramp_nxt = ramp_up;
        end else begin
          if (ramp_q == ZERO) dir_nxt  = DIR_UP;
          else                ramp_nxt = ramp_dn;
        end
      end
      default: ;
    endcase
  end

  // Ramp FSM state advances on the period tick; BREATHE entry re-arms upward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ramp_q  <= '0;
      phase_q <= P0;
      dir_q   <= DIR_UP;
    end else if (period_tick) begin
      ramp_q  <= ramp_nxt;
      phase_q <= phase_nxt;
      dir_q   <= dir_nxt;
    end else if (entering_br) begin
      dir_q   <= DIR_UP;
    end
  end

  assign inv = MAXR - ramp_nxt;

  // Duty targets for the period about to start, packed {B,G,R}.
  always_comb begin
    tgt = '0;
    if (md == BREATHE) begin
      tgt = {NUM_CH{ramp_nxt}};
    end else begin
      case (phase_nxt)
        P0:      tgt = {ZERO, ramp_nxt, MAXR};
        P1:      tgt = {ZERO, MAXR, inv};
        P2:      tgt = {ramp_nxt, MAXR, ZERO};
        P3:      tgt = {MAXR, inv, ZERO};
        P4:      tgt = {MAXR, ZERO, ramp_nxt};
        default: tgt = {inv, ZERO, MAXR};
      endcase
    end
  end

`ifdef HUE_FADE_GAMMA_EN
  localparam logic [2*RW-1:0] SQ_DIV = (2*RW)'(PWM_INTERVAL);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_gamma
    logic [2*RW-1:0] sq;
    assign sq         = {{RW{1'b0}}, tgt[c]} * {{RW{1'b0}}, tgt[c]};
    assign applied[c] = RW'(sq / SQ_DIV);
  end
`else
  assign applied = tgt;
`endif

  // Duties load on the tick in WHEEL/BREATHE, freeze in HOLD, clear in OFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   duty_q <= '0;
    else if (md == OFF)                                        duty_q <= '0;
    else if (period_tick && (md == WHEEL || md == BREATHE))    duty_q <= applied;
  end

  // OFF blanks the lanes on the very next clock, ahead of the cleared registers.
  assign duty_eff = (md == OFF) ? '0 : duty_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pwm_channel #(.PWM_INTERVAL(PWM_INTERVAL)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .count (cnt),
      .duty  (duty_eff[c]),
      .lit   (lit[c])
    );
  end

  assign rgb_out = (ACTIVE_LOW != 0) ? ~lit : lit;

endmodule

// File: tb/tb_hue_fade_engine.sv
// Self-checking bench for hue_fade_engine with a scaled period (M=120).
// A tick-level model tracks ramp/phase/direction and the duty per channel;
// each PWM period the bench counts lit cycles per channel and compares.
module tb_hue_fade_engine;

  localparam int M  = 120;
  localparam int S  = 10;
  localparam int AL = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [2:0] rgb_out;
  logic [2:0] phase;
  logic       period_tick;

  int checks   = 0;
  int failures = 0;

  int ramp_m, phase_m, dn_m, prev_mode;
  int duty_m[3];
  int lc[3];
  logic [2:0] first_rgb;

  hue_fade_engine #(.PWM_INTERVAL(M), .DUTY_STEP(S), .ACTIVE_LOW(AL)) dut (
    .clk         (clk),
    .rst         (rst),
    .mode        (mode),
    .rgb_out     (rgb_out),
    .phase       (phase),
    .period_tick (period_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int gam(input int d);
`ifdef HUE_FADE_GAMMA_EN
    return (d * d) / M;
`else
    return d;
`endif
  endfunction

  // Duties straight from the colour table (R,G,B) or the breathe rule.
  task automatic load_duties(input int md);
    int r, q;
    r = ramp_m;
    q = M - ramp_m;
    if (md == 1) duty_m = '{r, r, r};
    else begin
      case (phase_m)
        0:       duty_m = '{M, r, 0};
        1:       duty_m = '{q, M, 0};
        2:       duty_m = '{0, M, r};
        3:       duty_m = '{0, q, M};
        4:       duty_m = '{r, 0, M};
        default: duty_m = '{M, 0, q};
      endcase
    end
  endtask

  // Effect of one period tick taken in mode md.
  task automatic model_tick(input int md);
    case (md)
      0: begin
        if (ramp_m == M) begin ramp_m = 0; phase_m = (phase_m + 1) % 6; end
        else ramp_m = (ramp_m + S > M) ? M : ramp_m + S;
        load_duties(0);
      end
      1: begin
        if (dn_m == 0) begin
          if (ramp_m == M) dn_m = 1;
          else ramp_m = (ramp_m + S > M) ? M : ramp_m + S;
        end else begin
          if (ramp_m == 0) dn_m = 0;
          else ramp_m = (ramp_m - S < 0) ? 0 : ramp_m - S;
        end
        load_duties(1);
      end
      3: duty_m = '{0, 0, 0};
      default: ;
    endcase
  endtask

  // Called at the negedge just after a tick. Counts lit cycles over the
  // M output samples that correspond to counts 0..M-1 of this period.
  task automatic run_period(input int md);
    bit tick_ok;
    logic [2:0] lit;
    if (md == 1 && prev_mode != 1) dn_m = 0;
    if (md == 3) duty_m = '{0, 0, 0};
    mode = 2'(md);
    prev_mode = md;
    chk("phase", 32'(phase), phase_m);
    lc = '{0, 0, 0};
    tick_ok = 1'b1;
    for (int k = 1; k <= M; k++) begin
      @(negedge clk);
      if (k == 1) first_rgb = rgb_out;
      lit = (AL != 0) ? ~rgb_out : rgb_out;
      for (int c = 0; c < 3; c++) lc[c] += int'(lit[c]);
      if (period_tick !== 1'(k == M - 1)) tick_ok = 1'b0;
    end
    chk("lit_r", lc[0], gam(duty_m[0]));
    chk("lit_g", lc[1], gam(duty_m[1]));
    chk("lit_b", lc[2], gam(duty_m[2]));
    chk("tick_position", 32'(tick_ok), 1);
    model_tick(md);
  endtask

  // Release reset at a negedge, measure the distance to the first tick
  // (counting the release cycle as cycle 1), and align after that tick.
  task automatic release_and_sync(input int md);
    int cyc;
    mode = 2'(md);
    prev_mode = md;
    @(negedge clk);
    rst = 1'b0;
    cyc = 1;
    while (period_tick !== 1'b1 && cyc < 3 * M) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_tick_cycle", cyc, M);
    @(negedge clk);
    ramp_m = 0; phase_m = 0; dn_m = 0; duty_m = '{0, 0, 0};
    model_tick(md);
  endtask

  initial begin
    rst = 1'b1;
    mode = 2'd0;
    prev_mode = 0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", 32'(rgb_out), 32'(3'b111));
    chk("reset_tick", 32'(period_tick), 0);
    chk("reset_phase", 32'(phase), 0);
    release_and_sync(0);

    // Hue wheel: 13 ticks per phase, full turn after 78 ticks.
    for (int i = 1; i <= 80; i++) begin
      if (i == 13) chk("wheel_phase_after_13", 32'(phase), 1);
      if (i == 77) chk("wheel_phase_after_77", 32'(phase), 5);
      if (i == 78) chk("wheel_phase_after_78", 32'(phase), 0);
      run_period(0);
      if (i == 1) chk("wheel_p0_r_full", lc[0], gam(M));
      if (i == 1) chk("wheel_p0_b_dark", lc[2], 0);
      if (i == 6) chk("wheel_p0_g_half", lc[1], gam(M / 2));
    end

    // Hold at ramp 30 for 10 periods, then off, then resume wheel.
    for (int i = 0; i < 10; i++) run_period(2);
    chk("hold_g", lc[1], gam(M / 4));
    run_period(3);
    chk("off_next_cycle", 32'(first_rgb), 32'(3'b111));
    run_period(3);
    run_period(0);
    run_period(0);
    chk("resume_g_40", lc[1], gam(M / 3));

    // Mid-period reset, then breathe from ramp 0.
    repeat (50) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_rgb_now", 32'(rgb_out), 32'(3'b111));
    chk("midreset_tick", 32'(period_tick), 0);
    repeat (5) @(negedge clk);
    chk("midreset_rgb_hold", 32'(rgb_out), 32'(3'b111));
    chk("midreset_phase", 32'(phase), 0);
    release_and_sync(1);

    for (int i = 1; i <= 26; i++) begin
      run_period(1);
      if (i == 6)  chk("breathe_half_gamma", lc[0], gam(M / 2));
      if (i == 12) chk("breathe_top", lc[1], gam(M));
      if (i == 13) chk("breathe_top_reverse", lc[2], gam(M));
      if (i == 25) chk("breathe_bottom", lc[0], 0);
    end

    // Random mode sequence against the model.
    for (int i = 0; i < 30; i++) run_period(int'($urandom_range(0, 3)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
